mcu_pixel_streamer: RTL and testbench

MCU_PIXEL_STREAMER -- requirements
Module: mcu_pixel_streamer

---
 rtl/mcu_pixel_streamer.sv | 174 +++++++++++++++++
 tb/tb_mcu_pixel_streamer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mcu_pixel_streamer.sv
// Streams a frame held as a grid of 8x8 MCUs out in image raster order through
// a valid/ready pixel port, selecting each MCU from an upstream multiplexer.
module mcu_pixel_streamer #(
  parameter int MCU_COLS = 7,
  parameter int MCU_ROWS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [10:0]                   mcu_sel,
  input  logic [7:0][7:0][DATA_W-1:0]   mcu_in,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix_eol,
  output logic                          pix_eof,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int MC_W = (MCU_COLS > 1) ? $clog2(MCU_COLS) : 1;
  localparam int MR_W = (MCU_ROWS > 1) ? $clog2(MCU_ROWS) : 1;
  localparam logic [MC_W-1:0] MC_LAST  = MC_W'(MCU_COLS - 1);
  localparam logic [MR_W-1:0] MR_LAST  = MR_W'(MCU_ROWS - 1);
  localparam logic [10:0]     COLS_SEL = 11'(MCU_COLS);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  state_t state_q, state_nxt;

  // Stage p0: read address (pixel-in-MCU and MCU-in-frame counters)
  logic [2:0]       x_p0, x_nxt;
  logic [2:0]       y_p0, y_nxt;
  logic [MC_W-1:0]  mc_p0, mc_nxt;
  logic [MR_W-1:0]  mr_p0, mr_nxt;
  logic [10:0]      row_base_p0, row_base_nxt;

  // Stage p1: registered pixel presented downstream
  logic [DATA_W-1:0] pix_data_p1, pix_data_nxt;
  logic              vld_p1, vld_nxt;
  logic              eol_p1, eol_nxt;
  logic              eof_p1, eof_nxt;

  logic busy_q, busy_nxt;
  logic done_q, done_nxt;

  logic x_last, y_last, mc_last, mr_last, frame_last;
  logic load, accept;
  logic [1:0] flags;

  function automatic logic [1:0] pix_flags(input logic x_l, input logic mc_l,
                                           input logic y_l, input logic mr_l);
    logic eol;
    eol = x_l && mc_l;
    return {eol && y_l && mr_l, eol};
  endfunction

  assign x_last     = (x_p0 == 3'd7);
  assign y_last     = (y_p0 == 3'd7);
  assign mc_last    = (mc_p0 == MC_LAST);
  assign mr_last    = (mr_p0 == MR_LAST);
  assign frame_last = x_last && mc_last && y_last && mr_last;
  assign flags      = pix_flags(x_last, mc_last, y_last, mr_last);

  assign accept = vld_p1 && pix_ready;
  assign load   = (state_q == RUN) && (!vld_p1 || pix_ready);

  // row_base tracks mr*MCU_COLS so the select never needs a multiplier
  assign mcu_sel = row_base_p0 + 11'(mc_p0);

  always_comb begin
    state_nxt    = state_q;
    x_nxt        = x_p0;
    y_nxt        = y_p0;
    mc_nxt       = mc_p0;
    mr_nxt       = mr_p0;
    row_base_nxt = row_base_p0;
    pix_data_nxt = pix_data_p1;
    vld_nxt      = vld_p1;
    eol_nxt      = eol_p1;
    eof_nxt      = eof_p1;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;

    case (state_q)
      IDLE: begin
        // busy stays high through the frame_done cycle, which also masks start there
        if (done_q) begin
          busy_nxt = 1'b0;
        end else if (start && !busy_q) begin
          state_nxt    = RUN;
          busy_nxt     = 1'b1;
          x_nxt        = '0;
          y_nxt        = '0;
          mc_nxt       = '0;
          mr_nxt       = '0;
          row_base_nxt = '0;
        end
      end

      RUN: begin
        if (load) begin
          pix_data_nxt = mcu_in[y_p0][x_p0];
          vld_nxt      = 1'b1;
          eol_nxt      = flags[0];
          eof_nxt      = flags[1];
          x_nxt        = x_p0 + 3'd1;
          if (x_last) begin
            mc_nxt = mc_last ? '0 : mc_p0 + 1'b1;
            if (mc_last) begin
              y_nxt = y_p0 + 3'd1;
              if (y_last) begin
                mr_nxt       = mr_last ? '0 : mr_p0 + 1'b1;
                row_base_nxt = mr_last ? '0 : row_base_p0 + COLS_SEL;
              end
            end
          end
          if (frame_last) state_nxt = LAST;
        end
      end

      LAST: begin
        if (accept) begin
          vld_nxt   = 1'b0;
          eol_nxt   = 1'b0;
          eof_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_p0        <= '0;
      y_p0        <= '0;
      mc_p0       <= '0;
      mr_p0       <= '0;
      row_base_p0 <= '0;
      pix_data_p1 <= '0;
      vld_p1      <= 1'b0;
      eol_p1      <= 1'b0;
      eof_p1      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      x_p0        <= x_nxt;
      y_p0        <= y_nxt;
      mc_p0       <= mc_nxt;
      mr_p0       <= mr_nxt;
      row_base_p0 <= row_base_nxt;
      pix_data_p1 <= pix_data_nxt;
      vld_p1      <= vld_nxt;
      eol_p1      <= eol_nxt;
      eof_p1      <= eof_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
    end
  end

  assign pix_data   = pix_data_p1;
  assign pix_valid  = vld_p1;
  assign pix_eol    = eol_p1;
  assign pix_eof    = eof_p1;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_mcu_pixel_streamer.sv
// Directed bench for mcu_pixel_streamer: a 7x4 instance and a 1x1 instance
// sharing one stimulus sequence, with a raster-order reference model.
module tb_mcu_pixel_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, pix_ready, garble;
  int   which;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic                   start_a, start_b;
  logic [10:0]            sel_a, sel_b;
  logic [7:0][7:0][31:0]  mcu_a, mcu_b;
  logic [31:0]            data_a, data_b;
  logic valid_a, valid_b, eol_a, eol_b, eof_a, eof_b;
  logic busy_a, busy_b, done_a, done_b;

  logic [31:0] o_data;
  logic [10:0] o_sel;
  logic o_valid, o_eol, o_eof, o_busy, o_done;

  assign start_a = start && (which == 0);
  assign start_b = start && (which == 1);

  // Upstream MCU multiplexer: word = {sel, y, x}; garble corrupts it on cycles that must not load
  always_comb begin
    for (int yy = 0; yy < 8; yy++) begin
      for (int xx = 0; xx < 8; xx++) begin
        mcu_a[yy][xx] = {15'd0, sel_a, 3'(yy), 3'(xx)} ^ (garble ? 32'hdead_0000 : 32'd0);
        mcu_b[yy][xx] = {15'd0, sel_b, 3'(yy), 3'(xx)};
      end
    end
  end

  always_comb begin
    o_data  = (which == 1) ? data_b  : data_a;
    o_sel   = (which == 1) ? sel_b   : sel_a;
    o_valid = (which == 1) ? valid_b : valid_a;
    o_eol   = (which == 1) ? eol_b   : eol_a;
    o_eof   = (which == 1) ? eof_b   : eof_a;
    o_busy  = (which == 1) ? busy_b  : busy_a;
    o_done  = (which == 1) ? done_b  : done_a;
  end

  mcu_pixel_streamer #(.MCU_COLS(7), .MCU_ROWS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mcu_sel(sel_a), .mcu_in(mcu_a),
    .pix_data(data_a), .pix_valid(valid_a), .pix_ready(pix_ready),
    .pix_eol(eol_a), .pix_eof(eof_a), .busy(busy_a), .frame_done(done_a));

  mcu_pixel_streamer #(.MCU_COLS(1), .MCU_ROWS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mcu_sel(sel_b), .mcu_in(mcu_b),
    .pix_data(data_b), .pix_valid(valid_b), .pix_ready(pix_ready),
    .pix_eol(eol_b), .pix_eof(eof_b), .busy(busy_b), .frame_done(done_b));

  function automatic logic [31:0] exp_pix(input int k, input int cols);
    int w, row, col, sel;
    w   = 8 * cols;
    row = k / w;
    col = k % w;
    sel = (row / 8) * cols + col / 8;
    return {15'd0, 11'(sel), 3'(row % 8), 3'(col % 8)};
  endfunction

  function automatic logic [10:0] exp_sel(input int k, input int cols);
    int w;
    w = 8 * cols;
    return 11'(((k / w) / 8) * cols + (k % w) / 8);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"},  o_data,  0);
    check({tag, "_eol"},   o_eol,   0);
    check({tag, "_eof"},   o_eof,   0);
    check({tag, "_busy"},  o_busy,  0);
    check({tag, "_done"},  o_done,  0);
    check({tag, "_sel"},   o_sel,   0);
  endtask

  // mode 0: ready held; 1: random ready; 2: 5-cycle stall on pixel 8; 3: start re-pulses
  task automatic run_frame(input int mode, input int abort_at);
    int cols, n, k, cyc, stall_cnt, fd_cnt, post;
    logic prev_stall, eof_acc_prev, rdy;
    logic [31:0] prev_data;
    logic [10:0] prev_sel;
    cols = (which == 1) ? 1 : 7;
    n    = (which == 1) ? 64 : 64 * 7 * 4;
    k = 0; cyc = 0; stall_cnt = 0; fd_cnt = 0; post = 0;
    prev_stall = 1'b0; eof_acc_prev = 1'b0; prev_data = '0; prev_sel = '0;

    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", o_busy, 1);
    check("valid_cycle1", o_valid, 0);
    check("sel_cycle1", o_sel, 0);
    @(negedge clk);
    check("valid_cycle2", o_valid, 1);
    check("first_pixel", o_data, 32'h0000_0000);

    while (post < 4 && cyc < 20000) begin
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_busy", o_busy, 0);
        check("post_reset_valid", o_valid, 0);
        check("post_reset_done", o_done, 0);
        return;
      end

      if (k < n) check("valid_no_bubble", o_valid, 1);
      else       check("valid_after_eof", o_valid, 0);
      if (o_valid && k < n) begin
        check("pix_data", o_data, exp_pix(k, cols));
        check("pix_eol", o_eol, ((k + 1) % (8 * cols)) == 0);
        check("pix_eof", o_eof, k == n - 1);
        if (k + 1 < n) check("mcu_sel", o_sel, exp_sel(k + 1, cols));
        if (prev_stall) begin
          check("hold_data", o_data, prev_data);
          check("hold_sel", o_sel, prev_sel);
        end
      end
      check("frame_done", o_done, eof_acc_prev);
      check("busy", o_busy, fd_cnt == 0);
      if (which == 1) check("sel_const_1x1", o_sel, 0);

      if (mode == 2 && k == 8) begin
        check("stall_sel", o_sel, 11'd1);
        check("stall_data", o_data, 32'h0000_0040);
      end
      if (mode == 2 && k == 9) check("resume_data", o_data, 32'h0000_0041);

      if (o_done) fd_cnt++;
      case (mode)
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = !(k == 8 && stall_cnt < 5);
        default: rdy = 1'b1;
      endcase
      if (mode == 2 && !rdy) stall_cnt++;
      garble = (mode == 2) && !rdy;
      start  = (mode == 3) && (k == 100 || o_done);

      pix_ready    = rdy;
      eof_acc_prev = o_valid && rdy && o_eof;
      prev_stall   = o_valid && !rdy;
      prev_data    = o_data;
      prev_sel     = o_sel;
      if (o_valid && rdy) k++;
      if (fd_cnt > 0) post++;
      cyc++;
      @(negedge clk);
    end

    start  = 1'b0;
    garble = 1'b0;
    check("frame_complete", post >= 4, 1);
    check("pixel_count", k, n);
    check("frame_done_count", fd_cnt, 1);
    check("busy_idle", o_busy, 0);
    check("valid_idle", o_valid, 0);
    if (mode == 2) check("stall_cycles", stall_cnt, 5);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0; garble = 1'b0; which = 0;
    @(negedge clk);
    check_all_zero("reset_a");
    which = 1;
    #1;
    check_all_zero("reset_b");
    which = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", o_busy, 0);
    check("idle_valid", o_valid, 0);

    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(3, -1);
    run_frame(0, 900);
    run_frame(0, -1);
    which = 1;
    #1;
    run_frame(0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
